microtest_monitor: RTL and testbench

Synthesizable, table-driven microcode test monitor. It observes retired microinstructions from the cpu core and applies checkpoint actions: pass markers, skip-redirects, bounded loops, fail traps and done traps. It also produces uPC redirects and overall test status. It sits beside the cpu in FPGA and simulation builds, so the same self-checking microcode tests run without a behavioural bench.

---
 rtl/microtest_pkg.sv | 38 +++
 rtl/microtest_monitor_if.sv | 31 +++
 rtl/microtest_match.sv | 33 +++
 rtl/microtest_monitor.sv | 219 +++++++++++++++++++++
 tb/tb_microtest_monitor.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microtest_pkg.sv
// microtest_pkg: shared types and opcode field layout for the microcode test monitor.
package microtest_pkg;

    // Checkpoint entry kinds
    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_PASS = 3'd1,
        KIND_SKIP = 3'd2,
        KIND_LOOP = 3'd3,
        KIND_FAIL = 3'd4,
        KIND_DONE = 3'd5
    } kind_t;

    // Overall test status; a timeout is reported as ST_FAIL with the timeout flag set
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } status_t;

    localparam logic [3:0] SQI_CONT = 4'd14;
    localparam logic [1:0] MAP_PE   = 2'd0;

    // Retired opcode field bounds (opcode is numbered [112:1])
    localparam int OP_SQI_HI = 112;
    localparam int OP_SQI_LO = 109;
    localparam int OP_A_HI   = 108;
    localparam int OP_A_LO   = 97;
    localparam int OP_MAP_HI = 96;
    localparam int OP_MAP_LO = 95;

    // A checkpoint label instruction is an sqi CONT mapped to PE
    function automatic logic is_cont(input logic [112:1] op);
        return (op[OP_SQI_HI:OP_SQI_LO] == SQI_CONT) && (op[OP_MAP_HI:OP_MAP_LO] == MAP_PE);
    endfunction

endpackage

// File: rtl/microtest_monitor_if.sv
// microtest_monitor_if: retire/redirect/event bus between the cpu core and the test monitor.
interface microtest_monitor_if
    import microtest_pkg::*;
#(
    parameter int NUM_CHECKS = 64,
    parameter int PC_W       = 12,
    parameter int IDX_W      = $clog2(NUM_CHECKS)
);
    logic              retire;
    logic [PC_W-1:0]   pc_x;
    logic [PC_W-1:0]   pc_f;
    logic [112:1]      opcode_x;

    logic              redir_valid;
    logic [PC_W-1:0]   redir_pc;
    logic              evt_valid;
    logic [IDX_W-1:0]  evt_idx;
    kind_t             evt_kind;

    // cpu side: reports retirements, consumes redirects and events
    modport master (
        output retire, pc_x, pc_f, opcode_x,
        input  redir_valid, redir_pc, evt_valid, evt_idx, evt_kind
    );

    // monitor side
    modport slave (
        input  retire, pc_x, pc_f, opcode_x,
        output redir_valid, redir_pc, evt_valid, evt_idx, evt_kind
    );
endinterface

// File: rtl/microtest_match.sv
// microtest_match: combinational hit detection for a single checkpoint entry.
module microtest_match
    import microtest_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic            valid_i,
    input  kind_t           kind_i,
    input  logic [PC_W-1:0] from_i,
    input  logic [PC_W-1:0] to_i,
    input  logic            is_cont_i,
    input  logic [PC_W-1:0] label_i,
    input  logic [PC_W-1:0] pc_x_i,
    input  logic [PC_W-1:0] pc_f_i,
    output logic            hit_o
);

    // Apply the per-kind match rule to the current retirement
    always_comb begin
        hit_o = 1'b0;
        if (valid_i) begin
            unique case (kind_i)
                KIND_PASS,
                KIND_LOOP: hit_o = is_cont_i && (label_i == from_i);
                KIND_SKIP: hit_o = (pc_x_i == from_i) && (pc_f_i == to_i);
                KIND_FAIL,
                KIND_DONE: hit_o = (pc_x_i == from_i);
                default:   hit_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/microtest_monitor.sv
// microtest_monitor: checkpoint table, loop counters, priority select and test status FSM.
module microtest_monitor
    import microtest_pkg::*;
#(
    parameter int  NUM_CHECKS = 64,
    parameter int  PC_W       = 12,
    parameter int  CNT_W      = 16,
    parameter int  LIMIT_W    = 32,
    localparam int IDX_W      = $clog2(NUM_CHECKS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  kind_t               cfg_kind,
    input  logic [PC_W-1:0]     cfg_from,
    input  logic [PC_W-1:0]     cfg_to,
    input  logic [PC_W-1:0]     cfg_target,
    input  logic [CNT_W-1:0]    cfg_max,
    input  logic [LIMIT_W-1:0]  cycle_limit,
    input  logic                start,
    microtest_monitor_if.slave  bus,
    output status_t             status,
    output logic                timeout,
    output logic [LIMIT_W-1:0]  cycles
);

    // Checkpoint table and per-entry loop counters
    kind_t              kind_q   [NUM_CHECKS];
    logic [PC_W-1:0]    from_q   [NUM_CHECKS];
    logic [PC_W-1:0]    to_q     [NUM_CHECKS];
    logic [PC_W-1:0]    target_q [NUM_CHECKS];
    logic [CNT_W-1:0]   max_q    [NUM_CHECKS];
    logic [CNT_W-1:0]   cnt_q    [NUM_CHECKS];

    // Status FSM and registered outputs
    status_t            status_q;
    logic               timeout_q;
    logic [LIMIT_W-1:0] cycles_q;
    logic               redir_valid_q;
    logic [PC_W-1:0]    redir_pc_q;
    logic               evt_valid_q;
    logic [IDX_W-1:0]   evt_idx_q;
    kind_t              evt_kind_q;

    // Decoded retirement
    logic               take;
    logic               cont;
    logic [PC_W-1:0]    label;
    logic               unused_opcode_bits;

    // Winning entry and derived next values
    logic [NUM_CHECKS-1:0] hit;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    kind_t              win_kind;
    logic [PC_W-1:0]    win_from;
    logic [PC_W-1:0]    win_target;
    logic [CNT_W:0]     cnt_d;
    logic               loop_again;
    logic               finish_hit;
    logic [LIMIT_W:0]   cycles_inc;
    logic [LIMIT_W-1:0] cycles_d;
    logic               limit_hit;

    // A retire in the cycle after a redirect belongs to the flushed path and is dropped
    assign take  = bus.retire && (status_q == ST_RUN) && !redir_valid_q;
    assign cont  = is_cont(bus.opcode_x);
    assign label = PC_W'(bus.opcode_x[OP_A_HI:OP_A_LO]);
    assign unused_opcode_bits = ^bus.opcode_x[OP_MAP_LO-1:1];

    for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_match
        microtest_match #(
            .PC_W (PC_W)
        ) u_match (
            .valid_i   (take),
            .kind_i    (kind_q[g]),
            .from_i    (from_q[g]),
            .to_i      (to_q[g]),
            .is_cont_i (cont),
            .label_i   (label),
            .pc_x_i    (bus.pc_x),
            .pc_f_i    (bus.pc_f),
            .hit_o     (hit[g])
        );
    end

    // Priority encoder: lowest matching index wins
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
            if (hit[i] && !win_valid) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    assign win_kind   = kind_q[win_idx];
    assign win_from   = from_q[win_idx];
    assign win_target = target_q[win_idx];
    assign cnt_d      = {1'b0, cnt_q[win_idx]} + {{CNT_W{1'b0}}, 1'b1};
    assign loop_again = cnt_d < {1'b0, max_q[win_idx]};
    assign finish_hit = win_valid && ((win_kind == KIND_FAIL) || (win_kind == KIND_DONE));

    assign cycles_inc = {1'b0, cycles_q} + {{LIMIT_W{1'b0}}, 1'b1};
    assign cycles_d   = (&cycles_q) ? cycles_q : cycles_inc[LIMIT_W-1:0];
    assign limit_hit  = (cycle_limit != '0) && (cycles_inc == {1'b0, cycle_limit});

    // Table writes, accepted only while idle; contents survive start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                kind_q[i]   <= KIND_NONE;
                from_q[i]   <= '0;
                to_q[i]     <= '0;
                target_q[i] <= '0;
                max_q[i]    <= '0;
            end
        end else if (cfg_we && (status_q == ST_IDLE)) begin
            kind_q[cfg_idx]   <= cfg_kind;
            from_q[cfg_idx]   <= cfg_from;
            to_q[cfg_idx]     <= cfg_to;
            target_q[cfg_idx] <= cfg_target;
            max_q[cfg_idx]    <= cfg_max;
        end
    end

    // Status FSM: checkpoint actions, loop counters, cycle count and timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q      <= ST_IDLE;
            timeout_q     <= 1'b0;
            cycles_q      <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            evt_valid_q   <= 1'b0;
            evt_idx_q     <= '0;
            evt_kind_q    <= KIND_NONE;
            for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            redir_valid_q <= 1'b0;
            evt_valid_q   <= 1'b0;
            if (start) begin
                status_q  <= ST_RUN;
                timeout_q <= 1'b0;
                cycles_q  <= '0;
                for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (status_q == ST_RUN) begin
                if (win_valid) begin
                    unique case (win_kind)
                        KIND_PASS: begin
                            evt_valid_q <= 1'b1;
                            evt_idx_q   <= win_idx;
                            evt_kind_q  <= win_kind;
                        end
                        KIND_SKIP: begin
                            evt_valid_q   <= 1'b1;
                            evt_idx_q     <= win_idx;
                            evt_kind_q    <= win_kind;
                            redir_valid_q <= 1'b1;
                            redir_pc_q    <= win_target;
                        end
                        KIND_LOOP: begin
                            if (loop_again) begin
                                redir_valid_q   <= 1'b1;
                                redir_pc_q      <= win_from;
                                cnt_q[win_idx]  <= cnt_d[CNT_W-1:0];
                            end else begin
                                evt_valid_q     <= 1'b1;
                                evt_idx_q       <= win_idx;
                                evt_kind_q      <= win_kind;
                                cnt_q[win_idx]  <= '0;
                            end
                        end
                        KIND_FAIL: begin
                            evt_valid_q <= 1'b1;
                            evt_idx_q   <= win_idx;
                            evt_kind_q  <= win_kind;
                            status_q    <= ST_FAIL;
                            timeout_q   <= 1'b0;
                        end
                        KIND_DONE: begin
                            evt_valid_q <= 1'b1;
                            evt_idx_q   <= win_idx;
                            evt_kind_q  <= win_kind;
                            status_q    <= ST_PASS;
                        end
                        default: ;
                    endcase
                end
                // A FAIL/DONE hit outranks the timeout; cycles stops counting on the exit edge
                if (!finish_hit) begin
                    if (limit_hit) begin
                        status_q  <= ST_FAIL;
                        timeout_q <= 1'b1;
                    end else begin
                        cycles_q  <= cycles_d;
                    end
                end
            end
        end
    end

    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;
    assign bus.evt_valid   = evt_valid_q;
    assign bus.evt_idx     = evt_idx_q;
    assign bus.evt_kind    = evt_kind_q;
    assign status          = status_q;
    assign timeout         = timeout_q;
    assign cycles          = cycles_q;

endmodule

// File: tb/tb_microtest_monitor.sv
// tb_microtest_monitor: directed and randomized checks against a rule-level model.
module tb_microtest_monitor;
    import microtest_pkg::*;

    localparam int NC  = 64;
    localparam int PW  = 12;
    localparam int CW  = 16;
    localparam int LW  = 8;
    localparam int IW  = 6;
    localparam int CYC_MAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    kind_t         cfg_kind;
    logic [PW-1:0] cfg_from, cfg_to, cfg_target;
    logic [CW-1:0] cfg_max;
    logic [LW-1:0] cycle_limit;
    logic          start;
    status_t       status;
    logic          timeout;
    logic [LW-1:0] cycles;

    always #5 clk = ~clk;

    microtest_monitor_if #(.NUM_CHECKS(NC), .PC_W(PW)) bus ();

    microtest_monitor #(
        .NUM_CHECKS (NC),
        .PC_W       (PW),
        .CNT_W      (CW),
        .LIMIT_W    (LW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_kind    (cfg_kind),
        .cfg_from    (cfg_from),
        .cfg_to      (cfg_to),
        .cfg_target  (cfg_target),
        .cfg_max     (cfg_max),
        .cycle_limit (cycle_limit),
        .start       (start),
        .bus         (bus),
        .status      (status),
        .timeout     (timeout),
        .cycles      (cycles)
    );

    // Reference model state
    kind_t   m_kind   [NC];
    int      m_from   [NC];
    int      m_to     [NC];
    int      m_target [NC];
    int      m_max    [NC];
    int      m_cnt    [NC];
    status_t m_status;
    bit      m_timeout;
    int      m_cycles;
    bit      m_redir;
    int      m_redir_pc;
    bit      m_evt;
    int      m_evt_idx;
    kind_t   m_evt_kind;

    int tests = 0;
    int fails = 0;
    int n_redir, n_evt;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_kind[i] = KIND_NONE; m_from[i] = 0; m_to[i] = 0;
            m_target[i] = 0; m_max[i] = 0; m_cnt[i] = 0;
        end
        m_status = ST_IDLE; m_timeout = 0; m_cycles = 0;
        m_redir = 0; m_redir_pc = 0; m_evt = 0; m_evt_idx = 0; m_evt_kind = KIND_NONE;
    endtask

    task automatic post_evt(input int i);
        m_evt = 1; m_evt_idx = i; m_evt_kind = m_kind[i];
    endtask

    // One clock of the specified behaviour, using the inputs currently driven
    task automatic model_step();
        bit      prev_redir;
        status_t st0;
        int      hit;
        bit      c;
        int      a, pcx, pcf;
        prev_redir = m_redir;
        st0 = m_status;
        hit = -1;
        m_redir = 0;
        m_evt = 0;
        if (start) begin
            m_status = ST_RUN; m_timeout = 0; m_cycles = 0;
            for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        end else if (st0 == ST_RUN) begin
            if (bus.retire && !prev_redir) begin
                c   = (bus.opcode_x[112:109] == 4'd14) && (bus.opcode_x[96:95] == 2'd0);
                a   = int'(bus.opcode_x[108:97]);
                pcx = int'(bus.pc_x);
                pcf = int'(bus.pc_f);
                for (int i = 0; i < NC && hit < 0; i++) begin
                    case (m_kind[i])
                        KIND_PASS, KIND_LOOP: if (c && a == m_from[i]) hit = i;
                        KIND_SKIP:            if (pcx == m_from[i] && pcf == m_to[i]) hit = i;
                        KIND_FAIL, KIND_DONE: if (pcx == m_from[i]) hit = i;
                        default: ;
                    endcase
                end
            end
            if (hit >= 0) begin
                case (m_kind[hit])
                    KIND_PASS: post_evt(hit);
                    KIND_SKIP: begin post_evt(hit); m_redir = 1; m_redir_pc = m_target[hit]; end
                    KIND_LOOP: begin
                        if (m_cnt[hit] + 1 < m_max[hit]) begin
                            m_redir = 1; m_redir_pc = m_from[hit]; m_cnt[hit]++;
                        end else begin
                            post_evt(hit); m_cnt[hit] = 0;
                        end
                    end
                    KIND_FAIL: begin post_evt(hit); m_status = ST_FAIL; m_timeout = 0; end
                    KIND_DONE: begin post_evt(hit); m_status = ST_PASS; end
                    default: ;
                endcase
            end
            if (m_status == ST_RUN) begin
                if (cycle_limit != 0 && m_cycles + 1 == int'(cycle_limit)) begin
                    m_status = ST_FAIL; m_timeout = 1;
                end else if (m_cycles < CYC_MAX) begin
                    m_cycles++;
                end
            end
        end
        if (cfg_we && st0 == ST_IDLE) begin
            m_kind[cfg_idx] = cfg_kind; m_from[cfg_idx] = int'(cfg_from);
            m_to[cfg_idx] = int'(cfg_to); m_target[cfg_idx] = int'(cfg_target);
            m_max[cfg_idx] = int'(cfg_max);
        end
    endtask

    task automatic check_all();
        check("status", status, m_status);
        check("timeout", timeout, m_timeout);
        check("cycles", cycles, m_cycles);
        check("redir_valid", bus.redir_valid, m_redir);
        if (m_redir) check("redir_pc", bus.redir_pc, m_redir_pc);
        check("evt_valid", bus.evt_valid, m_evt);
        if (m_evt) begin
            check("evt_idx", bus.evt_idx, m_evt_idx);
            check("evt_kind", bus.evt_kind, m_evt_kind);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_status", status, ST_IDLE);
        check("rst_timeout", timeout, 1'b0);
        check("rst_cycles", cycles, 0);
        check("rst_redir_valid", bus.redir_valid, 1'b0);
        check("rst_redir_pc", bus.redir_pc, 0);
        check("rst_evt_valid", bus.evt_valid, 1'b0);
        check("rst_evt_idx", bus.evt_idx, 0);
        check("rst_evt_kind", bus.evt_kind, KIND_NONE);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        if (bus.redir_valid) n_redir++;
        if (bus.evt_valid) n_evt++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_we = 0; start = 0; bus.retire = 0;
    endtask

    task automatic idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input int idx, input kind_t k, input int from, input int to,
                       input int target, input int mx);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_kind = k; cfg_from = PW'(from);
        cfg_to = PW'(to); cfg_target = PW'(target); cfg_max = CW'(mx);
        tick();
        cfg_we = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic ret(input int pcx, input int pcf, input logic [112:1] op);
        bus.retire = 1; bus.pc_x = PW'(pcx); bus.pc_f = PW'(pcf); bus.opcode_x = op;
        tick();
        bus.retire = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        model_reset();
        check_reset_vals();
        @(negedge clk);
        reset_n = 1;
    endtask

    function automatic logic [112:1] mk_op(input logic [3:0] sqi, input logic [11:0] a,
                                           input logic [1:0] map);
        logic [112:1] op;
        for (int i = 1; i <= 112; i++) op[i] = 1'($urandom);
        op[112:109] = sqi;
        op[108:97]  = a;
        op[96:95]   = map;
        return op;
    endfunction

    initial begin
        reset_n = 0;
        idle_inputs();
        cfg_idx = '0; cfg_kind = KIND_NONE; cfg_from = '0; cfg_to = '0;
        cfg_target = '0; cfg_max = '0; cycle_limit = '0;
        bus.pc_x = '0; bus.pc_f = '0; bus.opcode_x = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset_n = 1;

        // Table setup
        cfg(0, KIND_SKIP, 5, 3, 6, 0);
        cfg(1, KIND_PASS, 30, 0, 0, 0);
        cfg(2, KIND_LOOP, 477, 0, 0, 256);
        cfg(3, KIND_FAIL, 1278, 0, 0, 0);
        cfg(4, KIND_DONE, 1273, 0, 0, 0);
        do_start();

        // SKIP redirect, then a squashed retire in the redirect cycle
        ret(5, 3, mk_op(4'd3, 12'd0, 2'd0));
        check("skip_redir_pc", bus.redir_pc, 6);
        ret(5, 3, mk_op(4'd3, 12'd0, 2'd0));
        check("skip_squash", bus.redir_valid, 1'b0);

        // PASS on CONT PE label; same label on a different map is not a checkpoint
        ret(100, 0, mk_op(4'd14, 12'd30, 2'd0));
        check("pass_evt", bus.evt_kind, KIND_PASS);
        ret(100, 0, mk_op(4'd14, 12'd30, 2'd1));
        check("pass_map1", bus.evt_valid, 1'b0);

        // Bounded loop, run twice
        for (int rep = 0; rep < 2; rep++) begin
            n_redir = 0; n_evt = 0;
            for (int k = 0; k < 256; k++) begin
                ret(200, 0, mk_op(4'd14, 12'd477, 2'd0));
                idle(1);
            end
            check("loop_redirs", n_redir, 255);
            check("loop_evts", n_evt, 1);
        end
        check("cycles_sat", cycles, CYC_MAX);

        // Table write while running is ignored
        cfg(0, KIND_NONE, 0, 0, 0, 0);
        ret(5, 3, mk_op(4'd3, 12'd0, 2'd0));
        check("cfg_ignored", bus.redir_valid, 1'b1);
        idle(1);

        // DONE then sticky PASS
        ret(1273, 0, mk_op(4'd2, 12'd0, 2'd0));
        check("done_status", status, ST_PASS);
        ret(1278, 0, mk_op(4'd2, 12'd0, 2'd0));
        check("sticky_pass", status, ST_PASS);

        // Timeout after 100 clocks
        cycle_limit = 8'd100;
        do_start();
        idle(100);
        check("to_status", status, ST_FAIL);
        check("to_flag", timeout, 1'b1);
        check("to_cycles", cycles, 99);

        // FAIL match on the timeout cycle wins
        do_start();
        idle(99);
        ret(1278, 0, mk_op(4'd2, 12'd0, 2'd0));
        check("fail_over_to", timeout, 1'b0);
        check("fail_status", status, ST_FAIL);

        // Limit of one trips on the first running clock
        cycle_limit = 8'd1;
        do_start();
        idle(1);
        check("limit1", timeout, 1'b1);
        cycle_limit = 8'd0;

        // Overlap: LOOP at idx2 outranks PASS at idx7; reset during loop
        do_reset();
        cfg(7, KIND_PASS, 30, 0, 0, 0);
        cfg(2, KIND_LOOP, 30, 0, 0, 3);
        do_start();
        ret(10, 0, mk_op(4'd14, 12'd30, 2'd0));
        check("overlap_redir", bus.redir_pc, 30);
        idle(1);
        ret(10, 0, mk_op(4'd14, 12'd30, 2'd0));
        idle(1);
        ret(10, 0, mk_op(4'd14, 12'd30, 2'd0));
        check("overlap_idx", bus.evt_idx, 2);
        ret(10, 0, mk_op(4'd14, 12'd30, 2'd0));
        do_reset();
        do_start();
        ret(10, 0, mk_op(4'd14, 12'd30, 2'd0));
        check("cleared_table", bus.evt_valid | bus.redir_valid, 1'b0);

        // Randomized runs
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 0; k < 12; k++)
                cfg($urandom_range(0, 15), kind_t'($urandom_range(0, 5)), $urandom_range(0, 7),
                    $urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(0, 4));
            cycle_limit = ($urandom_range(0, 2) == 0) ? 8'd0 : LW'($urandom_range(30, 200));
            do_start();
            for (int k = 0; k < 250; k++) begin
                start      = ($urandom_range(0, 59) == 0);
                cfg_we     = ($urandom_range(0, 9) == 0);
                cfg_idx    = IW'($urandom_range(0, 15));
                cfg_kind   = kind_t'($urandom_range(0, 5));
                cfg_from   = PW'($urandom_range(0, 7));
                bus.retire = ($urandom_range(0, 9) < 7);
                bus.pc_x   = PW'($urandom_range(0, 7));
                bus.pc_f   = PW'($urandom_range(0, 3));
                bus.opcode_x = mk_op(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd14,
                                     12'($urandom_range(0, 7)),
                                     ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0);
                tick();
            end
            idle_inputs();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
